// File: rtl/key_debouncer.sv
// Synchronizes and debounces NKEYS raw push-button pins into a clean active-high
// level vector plus registered one-cycle press/release pulses.

module key_debounce_lane #(
    parameter int CNT_BITS        = 20,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int ACTIVE_LOW      = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic raw_i,
    output logic key_o,
    output logic press_o,
    output logic release_o,
    output logic pulse_d_o
);
    localparam logic                RST_LVL = logic'(ACTIVE_LOW != 0);
    localparam logic [CNT_BITS-1:0] CNT_MAX = CNT_BITS'(DEBOUNCE_CYCLES - 1);

    logic                s1_q, s2_q, p;
    logic                key_q, key_d;
    logic                press_q, press_d;
    logic                rel_q, rel_d;
    logic [CNT_BITS-1:0] cnt_q, cnt_d;

    // Polarity is normalised after the second sync flop: p = 1 means pressed.
    assign p = RST_LVL ? ~s2_q : s2_q;

    always_comb begin
        key_d   = key_q;
        cnt_d   = '0;
        press_d = 1'b0;
        rel_d   = 1'b0;
        if (p != key_q) begin
            if (cnt_q == CNT_MAX) begin
                key_d   = p;
                press_d = p;
                rel_d   = ~p;
            end else begin
                cnt_d = cnt_q + CNT_BITS'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q    <= RST_LVL;
            s2_q    <= RST_LVL;
            key_q   <= 1'b0;
            cnt_q   <= '0;
            press_q <= 1'b0;
            rel_q   <= 1'b0;
        end else begin
            s1_q    <= raw_i;
            s2_q    <= s1_q;
            key_q   <= key_d;
            cnt_q   <= cnt_d;
            press_q <= press_d;
            rel_q   <= rel_d;
        end
    end

    assign key_o     = key_q;
    assign press_o   = press_q;
    assign release_o = rel_q;
    assign pulse_d_o = press_d | rel_d;
endmodule

module key_debouncer #(
    parameter int NKEYS           = 4,
    parameter int CNT_BITS        = 20,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int ACTIVE_LOW      = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [NKEYS-1:0] key_raw_i,
    output logic [NKEYS-1:0] keys_o,
    output logic [NKEYS-1:0] key_press_o,
    output logic [NKEYS-1:0] key_release_o,
    output logic             key_changed_o
);
    logic [NKEYS-1:0] pulse_d;
    logic             changed_q;

    for (genvar i = 0; i < NKEYS; i++) begin : g_lane
        key_debounce_lane #(
            .CNT_BITS       (CNT_BITS),
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .ACTIVE_LOW     (ACTIVE_LOW)
        ) u_lane (
            .clk      (clk),
            .reset    (reset),
            .raw_i    (key_raw_i[i]),
            .key_o    (keys_o[i]),
            .press_o  (key_press_o[i]),
            .release_o(key_release_o[i]),
            .pulse_d_o(pulse_d[i])
        );
    end

    // Registered from the lanes' next-state pulses so it aligns with key_press/key_release.
    always_ff @(posedge clk) begin
        if (reset) changed_q <= 1'b0;
        else       changed_q <= |pulse_d;
    end

    assign key_changed_o = changed_q;
endmodule
